// File: rtl/updown_counter3.sv
// WIDTH-bit up/down counter built from toggle stages that all share one clock edge.
// Each stage toggles when every lower stage is 1 (up) or 0 (down), gated by t.

module updown_counter3_tstage (
  input  logic clk,
  input  logic res,
  input  logic i_t,
  output logic o_q
);
  logic r_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res)     r_q <= 1'b0;
    else if (i_t) r_q <= ~r_q;
  end

  assign o_q = r_q;
endmodule

module updown_counter3 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             t,
  input  logic             M,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);
  logic [WIDTH-1:0] w_tog;

  // Toggle enables form a prefix-AND chain over the selected polarity of lower stages.
  assign w_tog[0] = t;
  generate
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
      assign w_tog[i] = w_tog[i-1] & (M ? qb[i-1] : q[i-1]);
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      updown_counter3_tstage u_stage (
        .clk (clk),
        .res (res),
        .i_t (w_tog[i]),
        .o_q (q[i])
      );
    end
  endgenerate

  assign qb = ~q;
endmodule

// File: tb/tb_updown_counter3.sv
// Directed and random checks of updown_counter3 against an integer-arithmetic model.
module tb_updown_counter3;
  localparam int W   = 3;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic         t   = 1'b0;
  logic         M   = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] qb;

  int total = 0;
  int bad   = 0;
  int model = 0;

  updown_counter3 #(.WIDTH(W)) dut (
    .clk (clk),
    .res (res),
    .t   (t),
    .M   (M),
    .q   (q),
    .qb  (qb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag);
    logic [W-1:0] e;
    e = model[W-1:0];
    total++;
    assert (q === e) else begin
      bad++;
      $error("FAIL %s q: got %0d want %0d", tag, q, e);
    end
    total++;
    assert (qb === ~e) else begin
      bad++;
      $error("FAIL %s qb: got %0d want %0d", tag, qb, ~e);
    end
  endtask

  // Apply t/M, take one rising edge, advance the model, check 1 time unit later.
  task automatic step(input logic tt, input logic mm, input string tag);
    t = tt;
    M = mm;
    @(posedge clk);
    if (res && tt) model = mm ? (model + MOD - 1) % MOD : (model + 1) % MOD;
    #1;
    chk(tag);
  endtask

  // Assert reset between edges and verify the clear is immediate.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    res = 1'b0;
    model = 0;
    #1;
    chk(tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    res = 1'b1;
  endtask

  initial begin
    // Reset held from time 0 with enable active: edges must be ignored.
    t = 1'b1;
    #1;
    chk("reset_t0");
    for (int i = 0; i < 4; i++) step(1'b1, i[0], "reset_hold");

    release_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, "up");

    // From 001 back to 000, then nine down steps including the 000->111 wrap.
    step(1'b1, 1'b1, "down_to0");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, "down");

    // Now 111; down to 101, then flip to up at mid-cycle.
    step(1'b1, 1'b1, "dir_pre");
    step(1'b1, 1'b1, "dir_pre");
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "dir_switch");

    // 000 -> 011, then hold with M toggling, then resume upward.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "to_hold");
    for (int i = 0; i < 4; i++) step(1'b0, i[0], "hold");
    step(1'b1, 1'b0, "resume");

    // 100 -> 110, then clear between edges.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, "to_clr");
    async_reset("async_clr");
    step(1'b1, 1'b1, "clr_held");
    release_reset();
    step(1'b1, 1'b0, "post_clr");

    // Random enable/direction with occasional mid-cycle clears.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rnd_clr");
        release_reset();
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: sim time %0t, limit 200000", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
